// File: rtl/cdb_arbiter_rr_pkg.sv
// Shared definitions for the Common Data Bus arbiter: default widths, the FREE tag
// and the idle bus value that register_status and seletor_uf expect.
package cdb_arbiter_rr_pkg;

  localparam int          DEF_N_UF     = 4;
  localparam int          DEF_DATA_W   = 16;
  localparam int          DEF_TAG_W    = 3;
  localparam logic [15:0] DEF_NO_VALUE = 16'hFFF0;

  // Tag 0 means "no producer"; channel i broadcasts tag i+1.
  localparam int          FREE_TAG     = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter_rr.sv
// Common Data Bus arbiter: one holding slot per functional unit, round-robin
// selection among occupied slots, one registered (tag, value) broadcast per cycle.
module cdb_arbiter_rr
  import cdb_arbiter_rr_pkg::*;
#(
  parameter int                N_UF     = DEF_N_UF,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                TAG_W    = DEF_TAG_W,
  parameter logic [DATA_W-1:0] NO_VALUE = DATA_W'(DEF_NO_VALUE)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_UF-1:0]        Done,
  input  logic [N_UF*DATA_W-1:0] Q,
  output logic [N_UF-1:0]        Ack,
  output logic [N_UF-1:0]        Pending,
  output logic                   CDB_valid,
  output logic [TAG_W-1:0]       Qi_CDB,
  output logic [DATA_W-1:0]      Qi_CDB_data
);

  localparam int IDX_W = idx_width(N_UF);

  generate
    if (N_UF < 2 || (1 << TAG_W) <= N_UF) begin : g_bad_cfg
      $error("cdb_arbiter_rr: need N_UF >= 2 and 2**TAG_W > N_UF");
    end
  endgenerate

  logic [N_UF-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  qi_cdb_q, qi_cdb_d;
  logic [DATA_W-1:0] qi_cdb_data_q, qi_cdb_data_d;
  logic [DATA_W-1:0] slot_data [N_UF];

  logic [N_UF-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_grant;
  logic [N_UF-1:0]   ack;

  rr_arbiter #(.N(N_UF), .IDX_W(IDX_W)) u_rr (
    .req       (pending_q),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Handshake: a unit raises Done with Q and holds both stable; the result is taken
  // at the rising edge where Ack is high. A slot being drained this edge can refill.
  assign ack = Done & (~pending_q | grant) & {N_UF{~Reset}};

  for (genvar i = 0; i < N_UF; i++) begin : g_slot
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (ack[i]) data_d = Q[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) data_q <= '0;
      else       data_q <= data_d;
    end

    assign slot_data[i] = data_q;
  end

  always_comb begin
    pending_d     = (pending_q & ~grant) | ack;
    ptr_d         = ptr_q;
    cdb_valid_d   = any_grant;
    qi_cdb_d      = TAG_W'(FREE_TAG);
    qi_cdb_data_d = NO_VALUE;
    if (any_grant) begin
      ptr_d         = (int'(grant_idx) == N_UF - 1) ? '0 : grant_idx + IDX_W'(1);
      qi_cdb_d      = TAG_W'(grant_idx) + TAG_W'(1);
      qi_cdb_data_d = slot_data[grant_idx];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_q     <= '0;
      ptr_q         <= '0;
      cdb_valid_q   <= 1'b0;
      qi_cdb_q      <= TAG_W'(FREE_TAG);
      qi_cdb_data_q <= NO_VALUE;
    end else begin
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      qi_cdb_q      <= qi_cdb_d;
      qi_cdb_data_q <= qi_cdb_data_d;
    end
  end

  assign Ack         = ack;
  assign Pending     = pending_q;
  assign CDB_valid   = cdb_valid_q;
  assign Qi_CDB      = qi_cdb_q;
  assign Qi_CDB_data = qi_cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Bench for cdb_arbiter_rr: vector table, hand-written reset/hold sequences and a
// randomized run against a queue-based reference of the broadcast rules.
module tb_cdb_arbiter_rr;

  localparam int          N_UF   = 4;
  localparam int          DATA_W = 16;
  localparam int          TAG_W  = 3;
  localparam logic [15:0] IDLE   = 16'hFFF0;

  // ---------------- clock / reset / DUT ----------------
  logic                   Clock;
  logic                   Reset;
  logic [N_UF-1:0]        Done;
  logic [N_UF*DATA_W-1:0] Q;
  logic [N_UF-1:0]        Ack;
  logic [N_UF-1:0]        Pending;
  logic                   CDB_valid;
  logic [TAG_W-1:0]       Qi_CDB;
  logic [DATA_W-1:0]      Qi_CDB_data;

  cdb_arbiter_rr #(.N_UF(N_UF), .DATA_W(DATA_W), .TAG_W(TAG_W), .NO_VALUE(IDLE)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Done        (Done),
    .Q           (Q),
    .Ack         (Ack),
    .Pending     (Pending),
    .CDB_valid   (CDB_valid),
    .Qi_CDB      (Qi_CDB),
    .Qi_CDB_data (Qi_CDB_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  done;
    logic [63:0] q;
    logic [3:0]  ack;
    logic        valid;
    logic [2:0]  tag;
    logic [15:0] data;
    logic [3:0]  pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] done, input logic [63:0] q,
                              input logic [3:0] ack, input logic valid, input logic [2:0] tag,
                              input logic [15:0] data, input logic [3:0] pend);
    vec_t v;
    v.rst = rst; v.done = done; v.q = q; v.ack = ack;
    v.valid = valid; v.tag = tag; v.data = data; v.pend = pend;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int row);
    @(negedge Clock);
    Reset = v.rst;
    Done  = v.done;
    Q     = v.q;
    #1;
    chk($sformatf("row%0d ack", row),     Ack,         v.ack);
    chk($sformatf("row%0d valid", row),   CDB_valid,   v.valid);
    chk($sformatf("row%0d tag", row),     Qi_CDB,      v.tag);
    chk($sformatf("row%0d data", row),    Qi_CDB_data, v.data);
    chk($sformatf("row%0d pending", row), Pending,     v.pend);
  endtask

  // ---------------- reference model ----------------
  // exp_q[i] holds results accepted from unit i and not yet broadcast.
  logic [DATA_W-1:0] exp_q [N_UF][$];
  int                m_ptr;
  logic              m_bv;
  int                m_bch;
  logic [DATA_W-1:0] m_bdata;
  logic              uf_has [N_UF];
  logic [DATA_W-1:0] uf_val [N_UF];
  logic [N_UF-1:0]   m_ack;
  logic              obs_valid;
  logic [TAG_W-1:0]  obs_tag;

  task automatic model_reset();
    for (int i = 0; i < N_UF; i++) begin
      exp_q[i].delete();
      uf_has[i] = 1'b0;
      uf_val[i] = '0;
    end
    m_ptr = 0;
    m_bv  = 1'b0;
    m_bch = 0;
    m_bdata = '0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Done  = '0;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
  endtask

  // One cycle: units with no result in hand may produce one (req_mask), then the
  // bus and handshake are checked and the model advances across the next edge.
  task automatic model_step(input logic [N_UF-1:0] req_mask);
    int g;
    int idx;
    logic [N_UF-1:0] exp_pend;
    @(negedge Clock);
    for (int i = 0; i < N_UF; i++) begin
      if (!uf_has[i] && req_mask[i]) begin
        uf_has[i] = 1'b1;
        uf_val[i] = DATA_W'($urandom);
      end
      Done[i] = uf_has[i];
      Q[i*DATA_W +: DATA_W] = uf_val[i];
    end
    #1;
    obs_valid = CDB_valid;
    obs_tag   = Qi_CDB;
    chk("rnd valid", CDB_valid, m_bv);
    chk("rnd tag",   Qi_CDB,    m_bv ? m_bch + 1 : 0);
    chk("rnd data",  Qi_CDB_data, m_bv ? m_bdata : IDLE);
    g = -1;
    for (int k = 0; k < N_UF; k++) begin
      idx = (m_ptr + k) % N_UF;
      if (g < 0 && exp_q[idx].size() > 0) g = idx;
    end
    for (int i = 0; i < N_UF; i++) begin
      exp_pend[i] = exp_q[i].size() > 0;
      m_ack[i]    = uf_has[i] && (exp_q[i].size() == 0 || i == g);
    end
    chk("rnd pending", Pending, exp_pend);
    chk("rnd ack",     Ack,     m_ack);
    if (g >= 0) begin
      m_bv    = 1'b1;
      m_bch   = g;
      m_bdata = exp_q[g].pop_front();
      m_ptr   = (g + 1) % N_UF;
    end else begin
      m_bv = 1'b0;
    end
    for (int i = 0; i < N_UF; i++) begin
      if (m_ack[i]) begin
        exp_q[i].push_back(uf_val[i]);
        uf_has[i] = 1'b0;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc_s;
    int bc_s;
    Reset = 1'b1;
    Done  = '0;
    Q     = '0;
    model_reset();

    // single result, then four simultaneous results from ptr=0
    tbl.push_back(mk(1, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_0005, 4'b0001, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 1, 16'h0005, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 64'h0044_0033_0022_0011, 4'b1111, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b1111));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 1, 16'h0011, 4'b1110));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 2, 16'h0022, 4'b1100));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 3, 16'h0033, 4'b1000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 4, 16'h0044, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));
    // slot 2 occupied while unit 2 holds a second result
    tbl.push_back(mk(1, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b0111, 64'h0000_0030_0020_0010, 4'b0111, 0, 0, IDLE, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 64'h0000_00AA_0000_0000, 4'b0000, 0, 0, IDLE, 4'b0111));
    tbl.push_back(mk(0, 4'b0100, 64'h0000_00AA_0000_0000, 4'b0000, 1, 1, 16'h0010, 4'b0110));
    tbl.push_back(mk(0, 4'b0100, 64'h0000_00AA_0000_0000, 4'b0100, 1, 2, 16'h0020, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 3, 16'h0030, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 1, 3, 16'h00AA, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 0, 0, IDLE, 4'b0000));

    for (int r = 0; r < tbl.size(); r++) apply_vec(tbl[r], r);

    // reset asserted mid-cycle while a broadcast is on the bus
    do_reset();
    @(negedge Clock);
    Done = 4'b0011;
    Q    = 64'h0000_0000_2222_1111;
    @(negedge Clock);
    Done = 4'b0100;
    Q    = 64'h0000_3333_0000_0000;
    @(posedge Clock);
    #3;
    chk("t1 pre valid", CDB_valid, 1);
    Reset = 1'b1;
    #1;
    chk("t1 valid",   CDB_valid,   0);
    chk("t1 tag",     Qi_CDB,      0);
    chk("t1 data",    Qi_CDB_data, IDLE);
    chk("t1 pending", Pending,     0);
    chk("t1 ack",     Ack,         0);
    @(negedge Clock);
    Reset = 1'b0;
    Done  = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #1;
      chk("t1 post valid", CDB_valid, 0);
    end

    // reset pulse with three slots full, then a fresh result from unit 1
    do_reset();
    @(negedge Clock);
    Done = 4'b0111;
    Q    = 64'h0000_0003_0002_0001;
    @(negedge Clock);
    Done = '0;
    #1;
    chk("t6 pre pending", Pending, 4'b0111);
    #1;
    Reset = 1'b1;
    #1;
    chk("t6 pending", Pending, 0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #1;
      chk("t6 quiet valid", CDB_valid, 0);
    end
    @(negedge Clock);
    Done = 4'b0010;
    Q    = 64'h0000_0000_1234_0000;
    #1;
    chk("t6 ack", Ack, 4'b0010);
    @(negedge Clock);
    Done = '0;
    #1;
    chk("t6 latency valid", CDB_valid, 0);
    @(negedge Clock);
    #1;
    chk("t6 valid", CDB_valid,   1);
    chk("t6 tag",   Qi_CDB,      2);
    chk("t6 data",  Qi_CDB_data, 16'h1234);

    // units 0 and 1 always busy, unit 2 joins mid-stream
    do_reset();
    acc_s = -1;
    bc_s  = -1;
    for (int s = 0; s < 30; s++) begin
      model_step((s == 6) ? 4'b0111 : 4'b0011);
      if (bc_s < 0 && acc_s >= 0 && s > acc_s && obs_valid && obs_tag == 3) bc_s = s;
      if (acc_s < 0 && m_ack[2]) acc_s = s;
    end
    chk("t4 ch2 granted in time", (acc_s >= 0 && bc_s >= 0 && bc_s - acc_s <= N_UF + 1), 1);

    // randomized traffic with occasional resets
    do_reset();
    for (int s = 0; s < 800; s++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else model_step(N_UF'($urandom_range(0, 15)));
    end
    for (int s = 0; s < 8; s++) model_step('0);
    @(negedge Clock);
    #1;
    chk("drain pending", Pending, 0);
    chk("drain valid",   CDB_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
